// File: rtl/id_rx_pkg.sv
// Shared types and helpers for the ID frame receiver: byte/frame FSM states and baud divisor.
package id_rx_pkg;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} byte_state_t;

  typedef enum logic [1:0] {StHunt, StId, StChk} frame_state_t;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, start-bit centring, LSB-first data, stop-bit check.
module uart_byte_rx
  import id_rx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] byte_data,
  output logic       byte_ok,
  output logic       byte_err
);

  localparam int unsigned CntW = $clog2(BIT_CYCLES + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BIT_CYCLES / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BIT_CYCLES - 1);

  logic            s1_q, rs_q;
  byte_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            ok_q, ok_d, err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rs_q) begin
          state_d = StStart;
          bit_d   = '0;
        end
      end
      StStart: begin
        // Sample mid start bit so data samples fall mid-bit thereafter.
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rs_q) begin
            ok_d    = 1'b1;
            data_d  = shift_q;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b1;
      rs_q    <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= rx_in;
      rs_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign byte_data = data_q;
  assign byte_ok   = ok_q;
  assign byte_err  = err_q;

endmodule

// File: rtl/id_frame_receiver.sv
// ID frame receiver: SYNC + ID_BYTES payload + XOR checksum over uart_byte_rx.
// Define ID_TIMEOUT_EN to abandon a frame after TIMEOUT_CYCLES without byte activity.
module id_frame_receiver
  import id_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50000000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned ID_BYTES       = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  output logic [8*ID_BYTES-1:0] id_out,
  output logic                  id_valid,
  output logic                  frame_err,
  output logic                  rx_activity
);

  localparam int unsigned IdW = 8 * ID_BYTES;
  localparam logic [3:0]  LastByte = 4'(ID_BYTES - 1);

  logic [7:0] byte_data;
  logic       byte_ok, byte_err, timeout_hit;

  uart_byte_rx #(
    .BIT_CYCLES(bit_cycles(CLK_FREQ, BAUD))
  ) u_byte_rx (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .byte_data(byte_data),
    .byte_ok  (byte_ok),
    .byte_err (byte_err)
  );

  frame_state_t   state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     acc_q, acc_d;
  logic [IdW-1:0] assy_q, assy_d, id_q, id_d;
  logic           valid_q, valid_d, err_q, err_d, act_q, act_d;

`ifdef ID_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  // Fire one cycle early: frame_err is registered, so it lands TIMEOUT_CYCLES after byte_ok.
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 2);
  logic [ToW-1:0] to_q, to_d;

  always_comb begin
    to_d        = to_q;
    timeout_hit = 1'b0;
    if (byte_ok || byte_err) begin
      to_d = '0;
    end else if (state_q != StHunt) begin
      if (to_q == ToLast) begin
        timeout_hit = 1'b1;
        to_d        = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    assy_d  = assy_q;
    id_d    = id_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    act_d   = byte_ok;
    unique case (state_q)
      StHunt: begin
        if (byte_ok && byte_data == SYNC_BYTE) begin
          state_d = StId;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      StId: begin
        if (byte_ok) begin
          assy_d = (assy_q << 8) | IdW'(byte_data);
          acc_d  = acc_q ^ byte_data;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == LastByte) state_d = StChk;
        end else if (byte_err || timeout_hit) begin
          err_d   = 1'b1;
          state_d = StHunt;
        end
      end
      StChk: begin
        if (byte_ok) begin
          state_d = StHunt;
          if (byte_data == acc_q) begin
            id_d    = assy_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (byte_err || timeout_hit) begin
          err_d   = 1'b1;
          state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHunt;
      cnt_q   <= '0;
      acc_q   <= '0;
      assy_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      assy_q  <= assy_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      act_q   <= act_d;
    end
  end

  assign id_out      = id_q;
  assign id_valid    = valid_q;
  assign frame_err   = err_q;
  assign rx_activity = act_q;

endmodule

// File: tb/tb_id_frame_receiver.sv
// Directed bench for id_frame_receiver at 10 clocks per bit; build with ID_TIMEOUT_EN to cover timeout.
module tb_id_frame_receiver;

  localparam int BitCyc = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_in = 1'b1;
  logic [31:0] id_out;
  logic        id_valid, frame_err, rx_activity;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_act = 0, n_val = 0, n_err = 0, n_overlap = 0;
  int last_act_cyc = 0, last_err_cyc = 0;

  id_frame_receiver #(
    .CLK_FREQ      (1000),
    .BAUD          (100),
    .ID_BYTES      (4),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .id_out     (id_out),
    .id_valid   (id_valid),
    .frame_err  (frame_err),
    .rx_activity(rx_activity)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_activity === 1'b1) begin
      n_act = n_act + 1;
      last_act_cyc = cyc;
    end
    if (frame_err === 1'b1) begin
      n_err = n_err + 1;
      last_err_cyc = cyc;
    end
    if (id_valid === 1'b1) n_val = n_val + 1;
    if (id_valid === 1'b1 && frame_err === 1'b1) n_overlap = n_overlap + 1;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_in = 1'b0;
    repeat (BitCyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (BitCyc) @(negedge clk);
    end
    rx_in = stop;
    repeat (BitCyc) @(negedge clk);
    rx_in = 1'b1;
    repeat (BitCyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    send_byte(b4, 1'b1);
    send_byte(b5, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (id_out !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_id_out: got %h want 00000000", id_out);
    end
    n_checks++;
    if ({id_valid, frame_err, rx_activity} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_pulses: got %b want 000", {id_valid, frame_err, rx_activity});
    end
  endtask

  task automatic test_reset_mid_frame();
    int a0, v0, e0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    a0 = n_act; v0 = n_val; e0 = n_err;
    // Tail of the discarded frame must be ignored in HUNT.
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h08, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_val - v0 !== 0 || n_err - e0 !== 0) begin
      n_errors++;
      $display("FAIL midreset_no_event: got valid=%0d err=%0d want 0 0", n_val - v0, n_err - e0);
    end
    n_checks++;
    if (n_act - a0 !== 4) begin
      n_errors++;
      $display("FAIL midreset_activity: got %0d want 4", n_act - a0);
    end
    n_checks++;
    if (id_out !== 32'h0) begin
      n_errors++;
      $display("FAIL midreset_id_out: got %h want 00000000", id_out);
    end
  endtask

  task automatic test_good_frame();
    int a0, v0, e0;
    a0 = n_act; v0 = n_val; e0 = n_err;
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    n_checks++;
    if (n_act - a0 !== 6) begin
      n_errors++;
      $display("FAIL good_activity: got %0d want 6", n_act - a0);
    end
    n_checks++;
    if (n_val - v0 !== 1) begin
      n_errors++;
      $display("FAIL good_id_valid: got %0d want 1", n_val - v0);
    end
    n_checks++;
    if (n_err - e0 !== 0) begin
      n_errors++;
      $display("FAIL good_frame_err: got %0d want 0", n_err - e0);
    end
    n_checks++;
    if (id_out !== 32'h12345678) begin
      n_errors++;
      $display("FAIL good_id_out: got %h want 12345678", id_out);
    end
  endtask

  task automatic test_bad_checksum();
    int v0, e0;
    v0 = n_val; e0 = n_err;
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09);
    n_checks++;
    if (n_err - e0 !== 1 || n_val - v0 !== 0) begin
      n_errors++;
      $display("FAIL badsum_events: got err=%0d valid=%0d want 1 0", n_err - e0, n_val - v0);
    end
    n_checks++;
    if (id_out !== 32'h12345678) begin
      n_errors++;
      $display("FAIL badsum_id_out: got %h want 12345678", id_out);
    end
  endtask

  task automatic test_bad_stop();
    int v0, e0;
    v0 = n_val; e0 = n_err;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_err - e0 !== 1 || n_val - v0 !== 0) begin
      n_errors++;
      $display("FAIL badstop_events: got err=%0d valid=%0d want 1 0", n_err - e0, n_val - v0);
    end
    v0 = n_val; e0 = n_err;
    send_frame(8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22);
    n_checks++;
    if (n_val - v0 !== 1 || n_err - e0 !== 0) begin
      n_errors++;
      $display("FAIL recover_events: got valid=%0d err=%0d want 1 0", n_val - v0, n_err - e0);
    end
    n_checks++;
    if (id_out !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL recover_id_out: got %h want deadbeef", id_out);
    end
  endtask

  task automatic test_glitch_stray();
    int a0, v0, e0;
    a0 = n_act; v0 = n_val; e0 = n_err;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (n_act - a0 !== 0 || n_err - e0 !== 0 || n_val - v0 !== 0) begin
      n_errors++;
      $display("FAIL glitch_events: got act=%0d err=%0d valid=%0d want 0 0 0",
               n_act - a0, n_err - e0, n_val - v0);
    end
    send_byte(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_act - a0 !== 1 || n_err - e0 !== 0 || n_val - v0 !== 0) begin
      n_errors++;
      $display("FAIL stray_events: got act=%0d err=%0d valid=%0d want 1 0 0",
               n_act - a0, n_err - e0, n_val - v0);
    end
    n_checks++;
    if (id_out !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL stray_id_out: got %h want deadbeef", id_out);
    end
  endtask

  task automatic test_timeout();
    int v0, e0;
    v0 = n_val; e0 = n_err;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (260) @(negedge clk);
`ifdef ID_TIMEOUT_EN
    n_checks++;
    if (n_err - e0 !== 1) begin
      n_errors++;
      $display("FAIL timeout_err_count: got %0d want 1", n_err - e0);
    end
    // rx_activity trails byte_ok by one cycle, so the gap to frame_err is 199.
    n_checks++;
    if (last_err_cyc - last_act_cyc !== 199) begin
      n_errors++;
      $display("FAIL timeout_latency: got %0d want 199", last_err_cyc - last_act_cyc);
    end
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h08, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_val - v0 !== 0 || id_out !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL timeout_hunt: got valid=%0d id=%h want 0 deadbeef", n_val - v0, id_out);
    end
`else
    n_checks++;
    if (n_err - e0 !== 0) begin
      n_errors++;
      $display("FAIL notimeout_err: got %0d want 0", n_err - e0);
    end
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h08, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_val - v0 !== 1 || id_out !== 32'h12345678) begin
      n_errors++;
      $display("FAIL notimeout_complete: got valid=%0d id=%h want 1 12345678", n_val - v0, id_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_good_frame();
    test_bad_checksum();
    test_bad_stop();
    test_glitch_stray();
    test_timeout();
    n_checks++;
    if (n_overlap !== 0) begin
      n_errors++;
      $display("FAIL valid_err_overlap: got %0d want 0", n_overlap);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_frame_receiver.md
Name: id_frame_receiver

Overview:
- Serial front end of the ID receiver: deserialises an 8N1 UART-style line into bytes and frames them as SYNC + ID bytes + XOR checksum.
- Publishes the last good ID and emits single-cycle event pulses (id_valid, frame_err, rx_activity).
- The event pulses drive the status-LED pulse extenders directly downstream.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate. BIT_CYCLES = CLK_FREQ/BAUD (integer division); must be >= 4.
- ID_BYTES, 4, number of ID payload bytes per frame, range 1..8.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 500000, inter-byte timeout. Used only with ID_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- rx_in  in  1  asynchronous serial line, idle high.
- id_out  out  8*ID_BYTES  last valid ID; first received byte occupies the MSBs.
- id_valid  out  1  one-cycle pulse when id_out is updated.
- frame_err  out  1  one-cycle pulse on any frame failure.
- rx_activity  out  1  one-cycle pulse per correctly framed byte.

Behaviour:
- Reset values: all outputs 0, id_out 0. Synchroniser flops reset to 1, all FSMs to idle. Reset asserted mid-frame discards the partial frame; no pulse is emitted.
- rx_in passes through a 2-flop synchroniser; all sampling uses the synchronised signal rs.
- Byte receiver states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rs==0 -> START, clear bit counter.
  - START: wait BIT_CYCLES/2 cycles, then sample. rs==1 -> IDLE (glitch rejected, no event). rs==0 -> DATA.
  - DATA: sample every BIT_CYCLES cycles, 8 bits, LSB first, then -> STOP.
  - STOP: sample after BIT_CYCLES. rs==1 -> byte_ok pulse, return to IDLE. rs==0 -> byte_err pulse, enter BREAK.
  - BREAK: wait for rs==1, then -> IDLE.
- Frame FSM states: HUNT, ID, CHK.
  - HUNT: byte_ok with data==SYNC_BYTE -> ID, clear the byte count and XOR accumulator. Any other byte is ignored. byte_err in HUNT is ignored.
  - ID: each byte_ok shifts the byte into the assembly register and XORs it into the accumulator. After ID_BYTES bytes -> CHK.
  - CHK: byte_ok with data==accumulator -> id_out <= assembly register, id_valid=1, -> HUNT. Mismatch -> frame_err=1, -> HUNT, id_out unchanged.
  - byte_err while in ID or CHK -> frame_err=1, -> HUNT.
  - The SYNC byte is not included in the checksum. A SYNC value appearing inside ID or CHK is treated as data.
- Latency:
  - byte_ok occurs the cycle after the stop-bit sample.
  - id_valid, frame_err and rx_activity occur the cycle after byte_ok or byte_err.
  - id_out and id_valid change in the same cycle.
- rx_activity pulses for every byte_ok in any frame state.
- id_valid and frame_err are never asserted in the same cycle.

Optional Feature:
- Macro ID_TIMEOUT_EN.
- Defined:
  - A counter clears on every byte_ok and byte_err, and counts while the frame FSM is in ID or CHK.
  - Reaching TIMEOUT_CYCLES -> frame_err pulse and -> HUNT.
  - If a timeout and a byte event fall in the same cycle, the byte event wins.
- Undefined: no counter; the frame FSM waits indefinitely in ID or CHK.

Decomposition:
- Package id_rx_pkg holds:
  - byte_state_t enum (IDLE, START, DATA, STOP, BREAK);
  - frame_state_t enum (HUNT, ID, CHK);
  - function bit_cycles(clk_freq, baud).
- Sub-module uart_byte_rx contains the synchroniser, the byte FSM and the bit counters. It outputs byte_data[7:0], byte_ok and byte_err.
- id_frame_receiver instantiates uart_byte_rx and implements the frame FSM and the timeout.

Test Plan:
Bench settings: CLK_FREQ=1000, BAUD=100 (BIT_CYCLES=10), ID_BYTES=4, TIMEOUT_CYCLES=200.
- Reset: hold reset 5 cycles with rx_in=1, release -> all outputs 0 and id_out=0; assert reset mid-frame -> no pulse follows and the next good frame is accepted.
- Good frame A5 12 34 56 78 08 -> six rx_activity pulses, one id_valid pulse, id_out=0x12345678, frame_err stays 0.
- Bad checksum, frame A5 12 34 56 78 09 -> one frame_err pulse, no id_valid, id_out stays 0x12345678.
- Stop bit driven low on byte 0x34 -> frame_err pulse; after the line returns high, frame A5 DE AD BE EF 22 -> id_out=0xDEADBEEF with id_valid.
- Glitch (rx_in low 3 cycles, fewer than the 5-cycle half bit) and stray byte 0x55 in HUNT -> no events except one rx_activity pulse for 0x55.
- With ID_TIMEOUT_EN, send A5 12 then idle -> frame_err exactly 200 cycles after the 0x12 byte_ok, then HUNT; without the macro -> no pulse and the frame completes if finished later.
